fsm_lockstep_sequencer: RTL and testbench
=========================================

Name: fsm_lockstep_sequencer

Overview:
- Drives the shared input w of the binary-encoded and one-hot sequence-detector FSMs from a programmed bit pattern.
- Single-steps both FSMs in lockstep and compares their za outputs after every step.
- Counts za assertions and halts on the first disagreement between the two encodings.
- Sits between the board switches/buttons and the two FSM instances as their test-mode controller.

Parameters:
PAT_W, 16, pattern length capacity in bits (2..32)
IDX_W, 5, width of step index/counters; 2^IDX_W must exceed PAT_W
STEP_DIV, 4, idle cycles inserted in WAIT between steps (0 = no wait)

Ports:
Clk  input  1  system clock, all state on rising edge
R  input  1  asynchronous active-low reset
start  input  1  pulse/level; rising-edge-detected internally, begins a run
pattern  input  PAT_W  w stimulus; bit 0 applied first
length  input  IDX_W  number of steps to run; values > PAT_W clamp to PAT_W
za_bin  input  1  za from binary-encoded FSM
za_hot  input  1  za from one-hot FSM
w_out  output  1  w driven to both FSMs
step  output  1  one-cycle clock-enable to both FSMs
fsm_rst  output  1  active-high synchronous reset to both FSMs
busy  output  1  run in progress
done  output  1  run completed with no mismatch (sticky)
mismatch  output  1  za_bin != za_hot seen (sticky)
fail_idx  output  IDX_W  step index of first mismatch
za_count  output  IDX_W  number of steps with za_bin = 1

Behaviour:
- On R low (any time, including mid-run): state IDLE and all outputs 0; fail_idx, za_count and the start edge register cleared.
- start edge = start & ~start_q. Edges are ignored unless the state is IDLE, DONE or ERROR.
- States: IDLE, CLR, STEP, SAMPLE, WAIT, DONE, ERROR.
- Start edge in IDLE, DONE or ERROR:
  - Go to CLR.
  - Latch pattern and the clamped length (len_q).
  - Clear idx, za_count, fail_idx, done and mismatch.
- CLR (1 cycle):
  - fsm_rst = 1, busy = 1.
  - If len_q == 0, next state is DONE; otherwise STEP.
- STEP (1 cycle):
  - w_out = pattern_q[idx], step = 1, busy = 1.
  - The FSMs advance on this cycle's closing edge.
- SAMPLE (1 cycle, the cycle after STEP):
  - w_out holds its value; za_bin and za_hot are compared.
  - If they differ: fail_idx <= idx, mismatch <= 1, next state ERROR.
  - Else: za_count += za_bin, idx += 1.
  - Next state is DONE if idx+1 == len_q, WAIT if STEP_DIV > 0, otherwise STEP.
- WAIT:
  - Counts STEP_DIV cycles with busy = 1 and step = 0, then goes to STEP.
- DONE:
  - done = 1, busy = 0.
  - Holds until the next start edge.
- ERROR:
  - mismatch = 1, busy = 0, done = 0.
  - za_count retains the value from before the failing step.
  - Holds until the next start edge.
- step is never high on two consecutive cycles. fsm_rst and step are never high together.
- w_out is 0 outside STEP and SAMPLE.
- Step cycle cost: 2 + STEP_DIV cycles, except the last step, which costs 2.
- Total latency from start edge to done = 1 + len_q*2 + (len_q-1)*STEP_DIV cycles after the edge-detect cycle.
- The za_count arithmetic cannot overflow because len_q <= PAT_W < 2^IDX_W.
- pattern and length changes during a run have no effect; they are latched at start.

Test Plan:
- Reset: R low mid-WAIT with step/busy high → all outputs 0 within the same cycle; resume only on a new start edge.
- Pass run: pattern=16'h00F0, length=8, matching FSM models (za after two equal w) → 8 step pulses.
  - w_out sequence is 0,0,0,0,1,1,1,1.
  - Response: done=1, mismatch=0, za_count=5.
  - busy is high for 1+16+7*4 = 45 cycles.
- Zero/clamp: length=0 → one fsm_rst cycle, then done=1, za_count=0, no step. length=31 → exactly 16 step pulses.
- Mismatch: force za_hot inverted on step index 3 → state ERROR, mismatch=1, fail_idx=3, done=0, no further step pulses.
- Restart/ignore: start edge while busy → no effect on the run. start edge in ERROR → fsm_rst pulse, mismatch cleared, new run proceeds.
- Held start: start held high for 100 cycles → exactly one run.

Source files
------------

// File: rtl/fsm_lockstep_sequencer.sv
// ----------------------------------------------------------------------------
// fsm_lockstep_sequencer
//   Test-mode controller for a pair of sequence-detector FSMs (binary-encoded
//   and one-hot). It feeds both FSMs the same w stimulus from a latched bit
//   pattern and single-steps them together. After every step it compares their
//   za outputs, counts the za assertions, and halts on the first disagreement.
//
// Ports
//   Clk       system clock; all state changes on the rising edge
//   R         asynchronous active-low reset
//   start     rising edge begins a run (ignored while a run is in progress)
//   pattern   w stimulus, bit 0 applied first; latched at start
//   length    number of steps; values above PAT_W clamp to PAT_W; latched
//   za_bin    za from the binary-encoded FSM
//   za_hot    za from the one-hot FSM
//   w_out     w driven to both FSMs
//   step      one-cycle clock enable to both FSMs
//   fsm_rst   active-high synchronous reset to both FSMs
//   busy      run in progress
//   done      run finished with no mismatch (sticky until next start)
//   mismatch  za_bin != za_hot was seen (sticky until next start)
//   fail_idx  step index of the first mismatch
//   za_count  number of sampled steps with za_bin = 1
// ----------------------------------------------------------------------------
module fsm_lockstep_sequencer #(
  parameter int PAT_W    = 16,
  parameter int IDX_W    = 5,
  parameter int STEP_DIV = 4
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [IDX_W-1:0] length,
  input  logic             za_bin,
  input  logic             za_hot,
  output logic             w_out,
  output logic             step,
  output logic             fsm_rst,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [IDX_W-1:0] fail_idx,
  output logic [IDX_W-1:0] za_count
);

  localparam int               WC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [IDX_W-1:0] PAT_MAX = IDX_W'(PAT_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_STEP, S_SAMPLE, S_WAIT, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic             start_q;
  logic             start_edge;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] za_count_q, za_count_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             w_out_q, w_out_d;
  logic             step_q, step_d;
  logic             fsm_rst_q, fsm_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    len_d      = len_q;
    idx_d      = idx_q;
    za_count_d = za_count_q;
    fail_idx_d = fail_idx_q;
    wcnt_d     = wcnt_q;
    start_edge = start & ~start_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_edge) begin
          state_d    = S_CLR;
          pattern_d  = pattern;
          len_d      = (length > PAT_MAX) ? PAT_MAX : length;
          idx_d      = '0;
          za_count_d = '0;
          fail_idx_d = '0;
        end
      end
      S_CLR:  state_d = (len_q == '0) ? S_DONE : S_STEP;
      S_STEP: state_d = S_SAMPLE;
      S_SAMPLE: begin
        // The FSMs advanced on the closing edge of STEP, so za is settled here.
        if (za_bin != za_hot) begin
          fail_idx_d = idx_q;
          state_d    = S_ERROR;
        end else begin
          za_count_d = za_count_q + IDX_W'(za_bin);
          idx_d      = idx_q + IDX_W'(1);
          if (idx_d == len_q) begin
            state_d = S_DONE;
          end else if (STEP_DIV > 0) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_WAIT: begin
        if (int'(wcnt_q) >= STEP_DIV - 1) state_d = S_STEP;
        else                              wcnt_d  = wcnt_q + WC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    // w holds through SAMPLE because idx only advances at the end of SAMPLE.
    w_out_d    = ((state_d == S_STEP) || (state_d == S_SAMPLE)) &&
                 (|(pattern_d & (PAT_W'(1) << idx_d)));
    step_d     = (state_d == S_STEP);
    fsm_rst_d  = (state_d == S_CLR);
    busy_d     = (state_d == S_CLR) || (state_d == S_STEP) ||
                 (state_d == S_SAMPLE) || (state_d == S_WAIT);
    done_d     = (state_d == S_DONE);
    mismatch_d = (state_d == S_ERROR);
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      pattern_q  <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      za_count_q <= '0;
      fail_idx_q <= '0;
      wcnt_q     <= '0;
      w_out_q    <= 1'b0;
      step_q     <= 1'b0;
      fsm_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      za_count_q <= za_count_d;
      fail_idx_q <= fail_idx_d;
      wcnt_q     <= wcnt_d;
      w_out_q    <= w_out_d;
      step_q     <= step_d;
      fsm_rst_q  <= fsm_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign w_out    = w_out_q;
  assign step     = step_q;
  assign fsm_rst  = fsm_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mismatch = mismatch_q;
  assign fail_idx = fail_idx_q;
  assign za_count = za_count_q;

endmodule

// File: tb/tb_fsm_lockstep_sequencer.sv
// Bench for fsm_lockstep_sequencer: behavioural models of the two detector
// FSMs close the loop, a queue holds the expected w of every step, and a table
// of runs carries the expected end-of-run outputs.
module tb_fsm_lockstep_sequencer;
  localparam int PAT_W = 16, IDX_W = 5, STEP_DIV = 4;

  logic             Clk = 1'b0, R = 1'b1, start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [IDX_W-1:0] length = '0;
  logic             za_bin, za_hot;
  logic             w_out, step, fsm_rst, busy, done, mismatch;
  logic [IDX_W-1:0] fail_idx, za_count;

  fsm_lockstep_sequencer #(.PAT_W(PAT_W), .IDX_W(IDX_W), .STEP_DIV(STEP_DIV)) dut (
    .Clk(Clk), .R(R), .start(start), .pattern(pattern), .length(length),
    .za_bin(za_bin), .za_hot(za_hot), .w_out(w_out), .step(step),
    .fsm_rst(fsm_rst), .busy(busy), .done(done), .mismatch(mismatch),
    .fail_idx(fail_idx), .za_count(za_count)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Detector FSM model (identical for both encodings): tracks whether the last
  // two w values were equal, and presents za as a registered output, so the za
  // seen after step k reflects w[k-1] == w[k-2].
  logic m_have = 1'b0, m_last = 1'b0, m_eq = 1'b0, m_za = 1'b0;
  int   run_steps = 0;
  bit   inj_en = 1'b0;
  int   inj_idx = 0;
  always @(posedge Clk) begin
    if (fsm_rst) begin
      m_have <= 1'b0; m_last <= 1'b0; m_eq <= 1'b0; m_za <= 1'b0;
      run_steps <= 0;
    end else if (step) begin
      m_za      <= m_eq;
      m_eq      <= m_have && (w_out == m_last);
      m_last    <= w_out;
      m_have    <= 1'b1;
      run_steps <= run_steps + 1;
    end
  end
  assign za_bin = m_za;
  assign za_hot = m_za ^ (inj_en && (run_steps == inj_idx + 1));

  // Scoreboard: expected w per step is queued when a run is launched.
  bit exp_w_q[$];
  int step_cnt = 0, rst_cnt = 0, busy_cnt = 0;
  bit prev_step = 1'b0, last_w = 1'b0;
  always @(negedge Clk) begin
    if (!R) begin
      prev_step <= 1'b0;
    end else begin
      if (step) begin
        step_cnt <= step_cnt + 1;
        if (exp_w_q.size() == 0) chk("unexpected_step", 1, 0);
        else                     chk("w_out_step", int'(w_out), int'(exp_w_q.pop_front()));
        chk("step_with_fsm_rst", int'(fsm_rst), 0);
        chk("step_back_to_back", int'(prev_step), 0);
        last_w <= w_out;
      end else if (prev_step) begin
        chk("w_out_hold", int'(w_out), int'(last_w));
      end else begin
        chk("w_out_idle", int'(w_out), 0);
      end
      if (fsm_rst) rst_cnt  <= rst_cnt + 1;
      if (busy)    busy_cnt <= busy_cnt + 1;
      prev_step <= step;
    end
  end

  typedef struct {
    logic [PAT_W-1:0] pat;
    logic [IDX_W-1:0] len;
    bit inj; int inj_idx; bit poke; bit hold;
    int exp_steps; bit exp_done; bit exp_mis; int exp_fail; int exp_za; int exp_busy;
  } vec_t;
  vec_t tbl[8];

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_w_out"}, int'(w_out), 0);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_fsm_rst"}, int'(fsm_rst), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
    chk({tag, "_fail_idx"}, int'(fail_idx), 0);
    chk({tag, "_za_count"}, int'(za_count), 0);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int t;
    pattern = v.pat; length = v.len; inj_en = v.inj; inj_idx = v.inj_idx;
    step_cnt = 0; rst_cnt = 0; busy_cnt = 0;
    exp_w_q.delete();
    for (int i = 0; i < v.exp_steps; i++) exp_w_q.push_back(v.pat[i]);
    @(negedge Clk); start = 1'b1;
    if (v.hold) repeat (100) @(negedge Clk);
    else        @(negedge Clk);
    start = 1'b0;
    if (v.poke) begin
      repeat (10) @(negedge Clk);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
    end
    t = 0;
    while (!(done || mismatch) && t < 400) begin
      @(negedge Clk);
      t++;
    end
    chk($sformatf("v%0d_timeout", k), int'(t >= 400), 0);
    repeat (10) @(negedge Clk);
    chk($sformatf("v%0d_steps", k), step_cnt, v.exp_steps);
    chk($sformatf("v%0d_done", k), int'(done), int'(v.exp_done));
    chk($sformatf("v%0d_mismatch", k), int'(mismatch), int'(v.exp_mis));
    chk($sformatf("v%0d_fail_idx", k), int'(fail_idx), v.exp_fail);
    chk($sformatf("v%0d_za_count", k), int'(za_count), v.exp_za);
    chk($sformatf("v%0d_busy_cycles", k), busy_cnt, v.exp_busy);
    chk($sformatf("v%0d_fsm_rst_pulses", k), rst_cnt, 1);
    chk($sformatf("v%0d_busy_end", k), int'(busy), 0);
    chk($sformatf("v%0d_w_left", k), exp_w_q.size(), 0);
  endtask

  initial begin
    //          pat       len    inj  idx poke hold steps done mis fail za busy
    tbl[0] = '{16'h00F0, 5'd8,  1'b0, 0, 1'b0, 1'b0, 8,  1'b1, 1'b0, 0, 5,  45};
    tbl[1] = '{16'h00F0, 5'd0,  1'b0, 0, 1'b0, 1'b0, 0,  1'b1, 1'b0, 0, 0,  1};
    tbl[2] = '{16'hA5C3, 5'd31, 1'b0, 0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 0, 7,  93};
    tbl[3] = '{16'h00F0, 5'd8,  1'b1, 3, 1'b0, 1'b0, 4,  1'b0, 1'b1, 3, 1,  21};
    tbl[4] = '{16'h0001, 5'd1,  1'b0, 0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 0, 0,  3};
    tbl[5] = '{16'hFFFF, 5'd16, 1'b0, 0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 0, 14, 93};
    tbl[6] = '{16'h00F0, 5'd8,  1'b0, 0, 1'b0, 1'b1, 8,  1'b1, 1'b0, 0, 5,  45};
    tbl[7] = '{16'h0000, 5'd2,  1'b0, 0, 1'b0, 1'b0, 2,  1'b1, 1'b0, 0, 0,  9};

    #1 R = 1'b0;
    repeat (3) @(negedge Clk);
    check_outputs_zero("reset");
    R = 1'b1;
    repeat (2) @(negedge Clk);

    // Reset asserted in the middle of a WAIT gap.
    pattern = 16'h00F0; length = 5'd8; inj_en = 1'b0;
    step_cnt = 0; rst_cnt = 0; busy_cnt = 0;
    exp_w_q.delete();
    for (int i = 0; i < 8; i++) exp_w_q.push_back(pattern[i]);
    @(negedge Clk); start = 1'b1;
    @(negedge Clk); start = 1'b0;      // CLR
    repeat (3) @(negedge Clk);         // STEP, SAMPLE, first WAIT cycle
    chk("midwait_busy", int'(busy), 1);
    chk("midwait_step", int'(step), 0);
    chk("midwait_step_cnt", step_cnt, 1);
    #1 R = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge Clk); R = 1'b1;
    exp_w_q.delete();
    repeat (20) @(negedge Clk);
    chk("no_resume_steps", step_cnt, 1);
    chk("no_resume_busy", int'(busy), 0);
    chk("no_resume_done", int'(done), 0);

    for (int k = 0; k < 8; k++) run_vec(tbl[k], k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
